// File: rtl/fifo_serial_drain_if.sv
// Handshake bundle between the FIFO read port / control side and the serial drain.
// master drives control and FIFO read data; slave is the drain itself.
interface fifo_serial_drain_if #(
  parameter int unsigned DATA_W = 8
) ();
  logic              en;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              fifo_rd_en;
  logic              tx;
  logic              busy;
  logic [7:0]        frame_cnt;

  modport master (
    output en,
    output fifo_empty,
    output fifo_rd_data,
    input  fifo_rd_en,
    input  tx,
    input  busy,
    input  frame_cnt
  );

  modport slave (
    input  en,
    input  fifo_empty,
    input  fifo_rd_data,
    output fifo_rd_en,
    output tx,
    output busy,
    output frame_cnt
  );
endinterface

// File: rtl/fifo_serial_drain.sv
// Pops one byte per frame from the FIFO read port and sends it as an async 8N1/8E1 frame.
// tx, busy and fifo_rd_en decode from the state register so reset forces tx high at once.
module fifo_serial_drain #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  fifo_serial_drain_if.slave   bus
);

  localparam int unsigned BaudW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BitW  = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0]  DataLast = BitW'(DATA_W - 1);
  localparam logic [BitW-1:0]  StopLast = BitW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    StIdle, StPop, StLoad, StStart, StData, StParity, StStop
  } state_e;

  state_e              state_q, state_d;
  logic [BaudW-1:0]    baud_q, baud_d;
  logic [BitW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic                parity_q, parity_d;
  logic [7:0]          frame_cnt_q, frame_cnt_d;
  logic                baud_last;
  logic                state_chg;

  assign baud_last = (baud_q == BaudLast);
  assign state_chg = (state_d != state_q);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (bus.en && !bus.fifo_empty) state_d = StPop;
      StPop:    state_d = StLoad;
      StLoad:   state_d = StStart;
      StStart:  if (baud_last) state_d = StData;
      StData: begin
        if (baud_last && (bit_q == DataLast)) begin
          state_d = (PARITY_EN != 0) ? StParity : StStop;
        end
      end
      StParity: if (baud_last) state_d = StStop;
      StStop:   if (baud_last && (bit_q == StopLast)) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Output decode
  always_comb begin
    bus.tx         = 1'b1;
    bus.busy       = 1'b1;
    bus.fifo_rd_en = 1'b0;
    unique case (state_q)
      StIdle:   bus.busy       = 1'b0;
      StPop:    bus.fifo_rd_en = 1'b1;
      StStart:  bus.tx         = 1'b0;
      StData:   bus.tx         = shreg_q[0];
      StParity: bus.tx         = parity_q;
      default:  ;
    endcase
  end

  assign bus.frame_cnt = frame_cnt_q;

  // Datapath: baud/bit counters restart on every state change
  always_comb begin
    baud_d      = baud_q;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    parity_d    = parity_q;
    frame_cnt_d = frame_cnt_q;

    if (state_chg || baud_last) begin
      baud_d = '0;
    end else begin
      baud_d = baud_q + BaudW'(1);
    end

    if (state_chg) begin
      bit_d = '0;
    end else if (baud_last && ((state_q == StData) || (state_q == StStop))) begin
      bit_d = bit_q + BitW'(1);
    end

    if (state_q == StLoad) begin
      shreg_d  = bus.fifo_rd_data;
      parity_d = ^bus.fifo_rd_data;
    end else if ((state_q == StData) && baud_last) begin
      shreg_d = shreg_q >> 1;
    end

    if ((state_q == StStop) && baud_last && (bit_q == StopLast)) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_q      <= '0;
      bit_q       <= '0;
      shreg_q     <= '0;
      parity_q    <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      parity_q    <= parity_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_serial_drain.sv
// Bench for fifo_serial_drain: one 8N1 instance and one 8E1 instance, each fed by a FIFO model;
// transmitted bytes are checked against a scoreboard of pushed bytes.
module tb_fifo_serial_drain;

  localparam int unsigned CPB = 4;

  typedef struct {
    bit         sel;
    logic [7:0] data;
    logic       par;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic en;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0] mem0 [0:511];
  logic [7:0] mem1 [0:63];
  int wr0 = 0, rd0 = 0, wr1 = 0, rd1 = 0;
  int bad_pop = 0;
  logic [7:0] exp0_q[$];
  logic [7:0] exp1_q[$];

  fifo_serial_drain_if #(.DATA_W(8)) bus ();
  fifo_serial_drain_if #(.DATA_W(8)) bus_p ();

  fifo_serial_drain #(
    .CLKS_PER_BIT(CPB),
    .DATA_W      (8),
    .PARITY_EN   (0),
    .STOP_BITS   (1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  fifo_serial_drain #(
    .CLKS_PER_BIT(CPB),
    .DATA_W      (8),
    .PARITY_EN   (1),
    .STOP_BITS   (1)
  ) dut_p (
    .clk(clk),
    .rst(rst),
    .bus(bus_p)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign bus.en           = en;
  assign bus_p.en         = en;
  assign bus.fifo_empty   = (wr0 == rd0);
  assign bus_p.fifo_empty = (wr1 == rd1);

  // FIFO models: read data valid the cycle after the pop strobe
  always @(posedge clk) begin
    if (bus.fifo_rd_en) begin
      if (wr0 == rd0) bad_pop <= bad_pop + 1;
      else begin
        bus.fifo_rd_data <= mem0[rd0[8:0]];
        rd0 <= rd0 + 1;
      end
    end
    if (bus_p.fifo_rd_en) begin
      if (wr1 == rd1) bad_pop <= bad_pop + 1;
      else begin
        bus_p.fifo_rd_data <= mem1[rd1[5:0]];
        rd1 <= rd1 + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic cur_tx(input bit sel);
    return sel ? bus_p.tx : bus.tx;
  endfunction

  function automatic logic cur_busy(input bit sel);
    return sel ? bus_p.busy : bus.busy;
  endfunction

  task automatic push_fifo(input bit sel, input logic [7:0] d);
    if (sel) begin
      mem1[wr1[5:0]] = d;
      wr1++;
    end else begin
      mem0[wr0[8:0]] = d;
      wr0++;
    end
  endtask

  task automatic push_byte(input bit sel, input logic [7:0] d);
    push_fifo(sel, d);
    if (sel) exp1_q.push_back(d);
    else     exp0_q.push_back(d);
  endtask

  task automatic wait_start(input bit sel, input int limit, output int s, output bit ok);
    ok = 1'b0;
    s  = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (cur_tx(sel) == 1'b0) begin
        s  = cyc;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL start_timeout: actual=no_start_bit required=start_bit");
    end
  endtask

  // Samples each bit mid-period; drop_bit >= 0 clears en at that frame bit
  task automatic rx_frame(input bit sel, input logic par_exp, input int drop_bit, output int s);
    logic [7:0] d;
    int         nb;
    int         k;
    bit         ok;
    logic       eb;
    d = 8'h00;
    if (sel ? (exp1_q.size() == 0) : (exp0_q.size() == 0)) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty: actual=empty required=expected_byte");
    end else if (sel) d = exp1_q.pop_front();
    else d = exp0_q.pop_front();
    wait_start(sel, 200, s, ok);
    if (!ok) return;
    nb = sel ? 11 : 10;
    k  = 0;
    for (int b = 0; b < nb; b++) begin
      while (k < b * CPB + 2) begin
        @(negedge clk);
        k++;
      end
      if (b == 0)                 eb = 1'b0;
      else if (b <= 8)            eb = d[b-1];
      else if ((b == 9) && sel)   eb = par_exp;
      else                        eb = 1'b1;
      chk("tx_bit", 32'(cur_tx(sel)), 32'(eb));
      if (b == drop_bit) en = 1'b0;
    end
    while (k < nb * CPB - 1) begin
      @(negedge clk);
      k++;
    end
    chk("busy_last_stop_cycle", 32'(cur_busy(sel)), 32'd1);
    @(negedge clk);
    chk("busy_after_frame", 32'(cur_busy(sel)), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs [9];
    int   s, s1, s2, rel, pops;
    int   cnt [2];
    bit   ok;
    bit   done;

    vecs[0] = '{1'b0, 8'h55, 1'b0};
    vecs[1] = '{1'b0, 8'h00, 1'b0};
    vecs[2] = '{1'b0, 8'hFF, 1'b0};
    vecs[3] = '{1'b0, 8'h81, 1'b0};
    vecs[4] = '{1'b1, 8'h07, 1'b1};
    vecs[5] = '{1'b1, 8'h00, 1'b0};
    vecs[6] = '{1'b1, 8'hFF, 1'b0};
    vecs[7] = '{1'b1, 8'h80, 1'b1};
    vecs[8] = '{1'b1, 8'h5A, 1'b0};
    cnt[0] = 0;
    cnt[1] = 0;

    // Reset held with a byte waiting
    rst = 1'b1;
    en  = 1'b1;
    push_byte(vecs[0].sel, vecs[0].data);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("reset_state", 32'({bus.tx, bus.fifo_rd_en, bus.busy, bus.frame_cnt}),
          32'({1'b1, 1'b0, 1'b0, 8'h00}));
    end
    rst = 1'b0;
    rel = cyc;

    for (int i = 0; i < 9; i++) begin
      if (i > 0) push_byte(vecs[i].sel, vecs[i].data);
      pops = vecs[i].sel ? rd1 : rd0;
      rx_frame(vecs[i].sel, vecs[i].par, -1, s);
      if (i == 0) chk("start_latency", 32'(s - rel), 32'd3);
      cnt[vecs[i].sel]++;
      chk("frame_cnt", 32'(vecs[i].sel ? bus_p.frame_cnt : bus.frame_cnt), 32'(cnt[vecs[i].sel]));
      chk("one_pop_per_frame", 32'(vecs[i].sel ? rd1 : rd0), 32'(pops + 1));
    end

    // Back-to-back frames
    pops = rd0;
    push_byte(1'b0, 8'hA3);
    push_byte(1'b0, 8'h3C);
    rx_frame(1'b0, 1'b0, -1, s1);
    rx_frame(1'b0, 1'b0, -1, s2);
    chk("b2b_start_spacing", 32'(s2 - s1), 32'(10 * CPB + 3));
    cnt[0] += 2;
    chk("b2b_frame_cnt", 32'(bus.frame_cnt), 32'(cnt[0]));
    chk("b2b_pops", 32'(rd0), 32'(pops + 2));

    // en low holds off pops; en dropped mid-frame finishes the frame only
    en = 1'b0;
    pops = rd0;
    push_byte(1'b0, 8'h96);
    repeat (20) @(negedge clk);
    chk("no_pop_en_low", 32'(rd0), 32'(pops));
    chk("idle_en_low", 32'({bus.busy, bus.tx}), 32'({1'b0, 1'b1}));
    en = 1'b1;
    push_byte(1'b0, 8'h4B);
    rx_frame(1'b0, 1'b0, 4, s);
    repeat (20) @(negedge clk);
    chk("single_pop_after_drop", 32'(rd0), 32'(pops + 1));
    chk("idle_after_drop", 32'(bus.busy), 32'd0);
    cnt[0]++;
    chk("drop_frame_cnt", 32'(bus.frame_cnt), 32'(cnt[0]));
    en = 1'b1;
    rx_frame(1'b0, 1'b0, -1, s);
    cnt[0]++;
    chk("resume_frame_cnt", 32'(bus.frame_cnt), 32'(cnt[0]));
    chk("resume_pops", 32'(rd0), 32'(pops + 2));

    // Reset during data bit 5
    push_fifo(1'b0, 8'hC3);
    wait_start(1'b0, 200, s, ok);
    repeat (6 * CPB + 2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_frame_tx", 32'(bus.tx), 32'd1);
    chk("rst_mid_frame_busy", 32'(bus.busy), 32'd0);
    chk("rst_mid_frame_cnt", 32'(bus.frame_cnt), 32'd0);
    chk("rst_par_cnt", 32'(bus_p.frame_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cnt[0] = 0;
    pops = rd0;
    push_byte(1'b0, 8'h3A);
    rx_frame(1'b0, 1'b0, -1, s);
    cnt[0]++;
    chk("post_rst_frame_cnt", 32'(bus.frame_cnt), 32'(cnt[0]));
    chk("post_rst_pops", 32'(rd0), 32'(pops + 1));

    // Frame counter wrap: 255 more frames take it from 1 back to 0
    for (int i = 0; i < 255; i++) push_fifo(1'b0, 8'(i));
    done = 1'b0;
    for (int i = 0; i < 255 * 50; i++) begin
      @(negedge clk);
      if ((rd0 == wr0) && !bus.busy) begin
        done = 1'b1;
        break;
      end
    end
    chk("wrap_drained", 32'(done), 32'd1);
    chk("frame_cnt_wrap", 32'(bus.frame_cnt), 32'd0);
    chk("no_pop_when_empty", 32'(bad_pop), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
